// File: rtl/lfsr_client_pkg.sv
// Shared types for the Fibonacci LFSR client: FSM state and index-width helper.
package lfsr_client_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-index width for a W-bit word; never below one bit.
    function automatic int unsigned idx_w(input int unsigned w);
        return (w > 2) ? int'($clog2(w)) : 1;
    endfunction

endpackage

// File: rtl/lfsr_fib_client_if.sv
// Word-side request/result handshake plus the LFSR server method pair.
// Optional check ports exist only when LFSR_CLIENT_CHECK_EN is defined.
interface lfsr_fib_client_if #(
    parameter int unsigned W      = 8,
    parameter int unsigned ECNT_W = 16
);
    logic         request__ENA;
    logic [W-1:0] request_v;
    logic         request__RDY;
    logic [W-1:0] result;
    logic         result__RDY;
    logic         resultAck__ENA;
    logic         resultAck__RDY;
    logic         shiftBit__ENA;
    logic         shiftBit_v;
    logic         shiftBit__RDY;
    logic         outBit;
    logic         outBit__RDY;
`ifdef LFSR_CLIENT_CHECK_EN
    logic [W-1:0]      expect_v;
    logic              errFlag;
    logic [ECNT_W-1:0] errCount;

    modport master (
        input  request__ENA, request_v, resultAck__ENA, shiftBit__RDY, outBit, outBit__RDY,
               expect_v,
        output request__RDY, result, result__RDY, resultAck__RDY, shiftBit__ENA, shiftBit_v,
               errFlag, errCount
    );
    modport slave (
        output request__ENA, request_v, resultAck__ENA, shiftBit__RDY, outBit, outBit__RDY,
               expect_v,
        input  request__RDY, result, result__RDY, resultAck__RDY, shiftBit__ENA, shiftBit_v,
               errFlag, errCount
    );
`else
    modport master (
        input  request__ENA, request_v, resultAck__ENA, shiftBit__RDY, outBit, outBit__RDY,
        output request__RDY, result, result__RDY, resultAck__RDY, shiftBit__ENA, shiftBit_v
    );
    modport slave (
        output request__ENA, request_v, resultAck__ENA, shiftBit__RDY, outBit, outBit__RDY,
        input  request__RDY, result, result__RDY, resultAck__RDY, shiftBit__ENA, shiftBit_v
    );
`endif
endinterface

// File: rtl/lfsr_fib_client.sv
// Shifts a W-bit word LSB-first into a Fibonacci LFSR server and captures the outBit samples.
// Define LFSR_CLIENT_CHECK_EN to compare each result against a latched expected word.
module lfsr_fib_client
    import lfsr_client_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned ECNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    lfsr_fib_client_if.master  bus
);

    localparam int unsigned IDX_W = idx_w(W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     data_q, data_d;
    logic [W-1:0]     result_q, result_d;
    logic             step_c;

`ifdef LFSR_CLIENT_CHECK_EN
    logic [W-1:0]      expect_q, expect_d;
    logic              err_flag_q, err_flag_d;
    logic [ECNT_W-1:0] err_cnt_q, err_cnt_d;
`endif

    // Next-state and datapath; the server handshake (step_c) is combinational.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        data_d   = data_q;
        result_d = result_q;
        step_c   = 1'b0;
`ifdef LFSR_CLIENT_CHECK_EN
        expect_d   = expect_q;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.request__ENA) begin
                    data_d   = bus.request_v;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = SHIFT;
`ifdef LFSR_CLIENT_CHECK_EN
                    expect_d = bus.expect_v;
`endif
                end
            end
            SHIFT: begin
                step_c = bus.shiftBit__RDY & bus.outBit__RDY;
                if (step_c) begin
                    // outBit is the pre-shift value, sampled alongside the ENA.
                    result_d[idx_q] = bus.outBit;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = DONE;
`ifdef LFSR_CLIENT_CHECK_EN
                        err_flag_d = (result_d != expect_q);
                        if ((result_d != expect_q) && (err_cnt_q != '1)) begin
                            err_cnt_d = err_cnt_q + ECNT_W'(1);
                        end
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.resultAck__ENA) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
`ifdef LFSR_CLIENT_CHECK_EN
            expect_q   <= '0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            result_q <= result_d;
`ifdef LFSR_CLIENT_CHECK_EN
            expect_q   <= expect_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign bus.request__RDY   = (state_q == IDLE);
    assign bus.result__RDY    = (state_q == DONE);
    assign bus.resultAck__RDY = (state_q == DONE);
    assign bus.result         = result_q;
    assign bus.shiftBit__ENA  = step_c;
    assign bus.shiftBit_v     = data_q[idx_q];
`ifdef LFSR_CLIENT_CHECK_EN
    assign bus.errFlag  = err_flag_q;
    assign bus.errCount = err_cnt_q;
`endif

    // Enables raised while the matching ready is low are ignored above but flagged here.
    always @(posedge CLK) begin
        if (RST) begin
            assert (W >= 1 && W <= 64 && ECNT_W >= 1)
                else $error("lfsr_fib_client: unsupported W/ECNT_W");
        end else begin
            assert (!(bus.request__ENA && state_q != IDLE))
                else $error("lfsr_fib_client: request__ENA while request__RDY=0");
            assert (!(bus.resultAck__ENA && state_q != DONE))
                else $error("lfsr_fib_client: resultAck__ENA while resultAck__RDY=0");
        end
    end

endmodule
